mem_bus_ctrl: RTL and testbench

Two-master memory bus controller that sits directly upstream of the memory container (lomem / pmon / himem). It arbitrates round-robin between the CPU port (m0) and the debug/loader port (m1) and decodes the word address into exactly one chip select. It sequences each transfer through a fixed four-state machine and returns registered read data with a one-cycle acknowledge. Memory reads are synchronous with one cycle of latency; this block absorbs that latency.

---
 rtl/mem_bus_ctrl_pkg.sv | 35 +++
 rtl/mem_bus_ctrl_addr_decode.sv | 37 +++
 rtl/mem_bus_ctrl.sv | 139 +++++++++++++
 tb/tb_mem_bus_ctrl.sv | 368 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_ctrl_pkg.sv
// Shared definitions for the two-master memory bus controller:
// FSM states, region codes and default memory map bases.
package mem_bus_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        RGN_NONE  = 2'd0,
        RGN_LOMEM = 2'd1,
        RGN_PMON  = 2'd2,
        RGN_HIMEM = 2'd3
    } region_t;

    localparam logic [31:0] DEF_PMON_BASE  = 32'h0000_F000;
    localparam logic [31:0] DEF_HIMEM_BASE = 32'h0001_0000;

    // One-hot select layout: bit 0 lomem, bit 1 pmon, bit 2 himem.
    function automatic region_t sel_to_region(input logic [2:0] sel);
        region_t rgn;
        rgn = RGN_NONE;
        case (sel)
            3'b001:  rgn = RGN_LOMEM;
            3'b010:  rgn = RGN_PMON;
            3'b100:  rgn = RGN_HIMEM;
            default: rgn = RGN_NONE;
        endcase
        return rgn;
    endfunction

endpackage

// File: rtl/mem_bus_ctrl_addr_decode.sv
// Combinational word-address decoder: pmon window wins over lomem,
// lomem wins over himem; anything else is unmapped.
module mem_addr_decode
    import mem_bus_ctrl_pkg::*;
#(
    parameter int unsigned LOMEM_SIZE = 65536,
    parameter logic [31:0] HIMEM_BASE = DEF_HIMEM_BASE,
    parameter int unsigned HIMEM_SIZE = 65536,
    parameter logic [31:0] PMON_BASE  = DEF_PMON_BASE
) (
    input  logic [31:0] addr,
    output logic [2:0]  sel,
    output logic        unmapped
);

    logic [32:0] w_addr33;
    logic [32:0] w_hi_lo;
    logic [32:0] w_hi_end;
    logic        w_pmon;
    logic        w_lomem;
    logic        w_himem;

    // 33-bit arithmetic so HIMEM_BASE + HIMEM_SIZE cannot wrap past 2^32.
    assign w_addr33 = {1'b0, addr};
    assign w_hi_lo  = {1'b0, HIMEM_BASE};
    assign w_hi_end = w_hi_lo + 33'(HIMEM_SIZE);

    assign w_pmon  = (addr[31:12] == PMON_BASE[31:12]);
    assign w_lomem = (w_addr33 < 33'(LOMEM_SIZE));
    assign w_himem = (HIMEM_SIZE != 0) && (w_addr33 >= w_hi_lo) && (w_addr33 < w_hi_end);

    assign sel[1]   = w_pmon;
    assign sel[0]   = w_lomem && !w_pmon;
    assign sel[2]   = w_himem && !w_pmon && !w_lomem;
    assign unmapped = !(w_pmon || w_lomem || w_himem);

endmodule

// File: rtl/mem_bus_ctrl.sv
// Round-robin two-master memory bus controller: grant, access, capture
// synchronous read data, then a one-cycle acknowledge to the granted port.
module mem_bus_ctrl
    import mem_bus_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned LOMEM_SIZE = 65536,
    parameter logic [31:0] HIMEM_BASE = DEF_HIMEM_BASE,
    parameter int unsigned HIMEM_SIZE = 65536,
    parameter logic [31:0] PMON_BASE  = DEF_PMON_BASE
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             m0_req,
    input  logic             m0_wen,
    input  logic [31:0]      m0_addr,
    input  logic [WIDTH-1:0] m0_wdata,
    output logic             m0_ack,
    output logic             m0_err,
    output logic [WIDTH-1:0] m0_rdata,
    input  logic             m1_req,
    input  logic             m1_wen,
    input  logic [31:0]      m1_addr,
    input  logic [WIDTH-1:0] m1_wdata,
    output logic             m1_ack,
    output logic             m1_err,
    output logic [WIDTH-1:0] m1_rdata,
    output logic [31:0]      mem_addr,
    output logic [WIDTH-1:0] mem_din,
    output logic             mem_wen,
    output logic             cs_lomem,
    output logic             cs_pmon,
    output logic             cs_himem,
    input  logic [WIDTH-1:0] mem_dout
);

    state_t           r_state;
    state_t           w_next_state;
    logic             r_last_grant;   // 0 = m0, 1 = m1
    logic             r_gnt;
    logic [31:0]      r_addr;
    logic [WIDTH-1:0] r_wdata;
    logic             r_wen;
    region_t          r_region;
    logic [WIDTH-1:0] r_m0_rdata;
    logic [WIDTH-1:0] r_m1_rdata;

    logic             w_grant_valid;
    logic             w_grant_sel;
    logic [31:0]      w_req_addr;
    logic [2:0]       w_sel;
    logic             w_unmapped;
    logic             w_access;
    logic             w_done;
    logic [WIDTH-1:0] w_rd_value;

    always_comb begin
        w_next_state  = r_state;
        w_grant_valid = 1'b0;
        w_grant_sel   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (m0_req || m1_req) begin
                    w_grant_valid = 1'b1;
                    w_grant_sel   = (m0_req && m1_req) ? ~r_last_grant : m1_req;
                    w_next_state  = ST_ACCESS;
                end
            end
            ST_ACCESS: w_next_state = ST_RESP;
            ST_RESP:   w_next_state = ST_DONE;
            ST_DONE:   w_next_state = ST_IDLE;
            default:   w_next_state = ST_IDLE;
        endcase
    end

    // Decode the address of whichever master is being granted this cycle.
    assign w_req_addr = w_grant_sel ? m1_addr : m0_addr;

    mem_addr_decode #(
        .LOMEM_SIZE (LOMEM_SIZE),
        .HIMEM_BASE (HIMEM_BASE),
        .HIMEM_SIZE (HIMEM_SIZE),
        .PMON_BASE  (PMON_BASE)
    ) u_decode (
        .addr     (w_req_addr),
        .sel      (w_sel),
        .unmapped (w_unmapped)
    );

    assign w_rd_value = (r_region == RGN_NONE) ? '0 : mem_dout;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_last_grant <= 1'b1;
            r_gnt        <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_wen        <= 1'b0;
            r_region     <= RGN_NONE;
            r_m0_rdata   <= '0;
            r_m1_rdata   <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_grant_valid) begin
                r_gnt    <= w_grant_sel;
                r_addr   <= w_req_addr;
                r_wdata  <= w_grant_sel ? m1_wdata : m0_wdata;
                r_wen    <= w_grant_sel ? m1_wen : m0_wen;
                r_region <= w_unmapped ? RGN_NONE : sel_to_region(w_sel);
            end
            if (r_state == ST_RESP && !r_wen) begin
                if (r_gnt) r_m1_rdata <= w_rd_value;
                else       r_m0_rdata <= w_rd_value;
            end
            if (r_state == ST_DONE) begin
                r_last_grant <= r_gnt;
            end
        end
    end

    assign w_access = (r_state == ST_ACCESS);
    assign w_done   = (r_state == ST_DONE);

    assign mem_addr = r_addr;
    assign mem_din  = r_wdata;
    assign cs_lomem = w_access && (r_region == RGN_LOMEM);
    assign cs_pmon  = w_access && (r_region == RGN_PMON);
    assign cs_himem = w_access && (r_region == RGN_HIMEM);
    assign mem_wen  = w_access && r_wen && (r_region != RGN_NONE);

    assign m0_ack   = w_done && !r_gnt;
    assign m1_ack   = w_done && r_gnt;
    assign m0_err   = m0_ack && (r_region == RGN_NONE);
    assign m1_err   = m1_ack && (r_region == RGN_NONE);
    assign m0_rdata = r_m0_rdata;
    assign m1_rdata = r_m1_rdata;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Bench for mem_bus_ctrl: memory emulator, transaction-level reference
// model compared every cycle, directed scenarios and random two-master traffic.
module tb_mem_bus_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        m0_req, m0_wen, m1_req, m1_wen;
    logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
    logic        m0_ack, m1_ack, m0_err, m1_err;
    logic [31:0] m0_rdata, m1_rdata, mem_addr, mem_din;
    logic [31:0] mem_dout = '0;
    logic        mem_wen, cs_lomem, cs_pmon, cs_himem;

    logic        n_req, n_wen;
    logic [31:0] n_addr, n_wdata;
    logic        n_ack, n_err, n1_ack, n1_err;
    logic [31:0] n_rdata, n1_rdata, n_mem_addr, n_mem_din;
    logic        n_mem_wen, n_cs_lo, n_cs_pm, n_cs_hi;

    int checks   = 0;
    int failures = 0;
    bit chk_on   = 1'b0;

    mem_bus_ctrl u_dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_wen(m0_wen), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_ack(m0_ack), .m0_err(m0_err), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_wen(m1_wen), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_ack(m1_ack), .m1_err(m1_err), .m1_rdata(m1_rdata),
        .mem_addr(mem_addr), .mem_din(mem_din), .mem_wen(mem_wen),
        .cs_lomem(cs_lomem), .cs_pmon(cs_pmon), .cs_himem(cs_himem),
        .mem_dout(mem_dout)
    );

    // Same controller with himem absent.
    mem_bus_ctrl #(.HIMEM_SIZE(0)) u_dut_nh (
        .clk(clk), .reset(reset),
        .m0_req(n_req), .m0_wen(n_wen), .m0_addr(n_addr), .m0_wdata(n_wdata),
        .m0_ack(n_ack), .m0_err(n_err), .m0_rdata(n_rdata),
        .m1_req(1'b0), .m1_wen(1'b0), .m1_addr(32'h0), .m1_wdata(32'h0),
        .m1_ack(n1_ack), .m1_err(n1_err), .m1_rdata(n1_rdata),
        .mem_addr(n_mem_addr), .mem_din(n_mem_din), .mem_wen(n_mem_wen),
        .cs_lomem(n_cs_lo), .cs_pmon(n_cs_pm), .cs_himem(n_cs_hi),
        .mem_dout(32'h0)
    );

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", nm, got, exp, $time);
        end
    endtask

    task automatic fail_now(input string nm);
        checks++;
        failures++;
        $display("FAIL %s timed out t=%0t", nm, $time);
    endtask

    // Region codes: 0 none, 1 lomem, 2 pmon, 3 himem (default map).
    function automatic int ref_region(input logic [31:0] a);
        if (a >= 32'h0000_F000 && a <= 32'h0000_FFFF) return 2;
        if (a < 32'd65536) return 1;
        if (a >= 32'h0001_0000 && a <= 32'h0001_FFFF) return 3;
        return 0;
    endfunction

    function automatic logic [31:0] dflt(input int rg, input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ (32'(rg) << 28);
    endfunction

    // Memory container: separate storage per chip select, one-cycle read latency.
    logic [31:0] emu [bit [33:0]];
    always @(posedge clk) begin : emu_blk
        int       rg;
        bit [33:0] k;
        rg = cs_pmon ? 2 : cs_lomem ? 1 : cs_himem ? 3 : 0;
        k  = {2'(rg), mem_addr};
        if (rg != 0) begin
            if (mem_wen) emu[k] = mem_din;
            else mem_dout <= emu.exists(k) ? emu[k] : dflt(rg, mem_addr);
        end
    end

    // Reference model: a transfer granted at edge g shows its chip select
    // after edge g, captures read data at edge g+2, acks after edge g+2,
    // and the next grant can happen at edge g+4.
    int          ecnt = 0;
    bit          act  = 1'b0;
    int          g    = 0;
    bit          gm, gw;
    bit          lastg = 1'b1;
    logic [31:0] ga, gd;
    int          grg;
    logic [31:0] exp_rd0 = '0, exp_rd1 = '0;
    logic [31:0] mmem [bit [31:0]];

    always @(posedge clk) begin : model
        logic [31:0] v;
        ecnt++;
        if (act && ecnt == g + 1 && gw && grg != 0) mmem[ga] = gd;
        if (reset) begin
            act = 1'b0; lastg = 1'b1; exp_rd0 = '0; exp_rd1 = '0;
        end else if (!act) begin
            if (m0_req || m1_req) begin
                gm  = (m0_req && m1_req) ? !lastg : m1_req;
                ga  = gm ? m1_addr : m0_addr;
                gd  = gm ? m1_wdata : m0_wdata;
                gw  = gm ? m1_wen : m0_wen;
                grg = ref_region(ga);
                g   = ecnt;
                act = 1'b1;
            end
        end else if (ecnt == g + 2) begin
            if (!gw) begin
                v = (grg == 0) ? 32'h0 : (mmem.exists(ga) ? mmem[ga] : dflt(grg, ga));
                if (gm) exp_rd1 = v; else exp_rd0 = v;
            end
        end else if (ecnt == g + 3) begin
            lastg = gm;
            act   = 1'b0;
        end
    end

    always @(negedge clk) begin : cmp
        int         d;
        logic [2:0] ecs;
        logic       ewen, ea0, ea1;
        if (chk_on) begin
            d    = act ? (ecnt - g) : -1;
            ecs  = '0; ewen = 1'b0; ea0 = 1'b0; ea1 = 1'b0;
            if (d == 0) begin
                ecs  = (grg == 1) ? 3'b001 : (grg == 2) ? 3'b010 : (grg == 3) ? 3'b100 : 3'b000;
                ewen = gw && (grg != 0);
                chk("mem_addr", mem_addr, ga);
                chk("mem_din", mem_din, gd);
            end
            if (d == 2) begin
                ea0 = !gm;
                ea1 = gm;
            end
            chk("cs_hi_pm_lo", {cs_himem, cs_pmon, cs_lomem}, ecs);
            chk("mem_wen", mem_wen, ewen);
            chk("m0_ack", m0_ack, ea0);
            chk("m1_ack", m1_ack, ea1);
            if (ea0) chk("m0_err", m0_err, grg == 0);
            if (ea1) chk("m1_err", m1_err, grg == 0);
            chk("m0_rdata", m0_rdata, exp_rd0);
            chk("m1_rdata", m1_rdata, exp_rd1);
        end
    end

    task automatic set_req(input bit m, input logic r, input logic w,
                           input logic [31:0] a, input logic [31:0] d);
        if (m) begin m1_req = r; m1_wen = w; m1_addr = a; m1_wdata = d; end
        else   begin m0_req = r; m0_wen = w; m0_addr = a; m0_wdata = d; end
    endtask

    // One transfer from an idle bus; masks record cs/wen at the first 4 negedges.
    task automatic xfer(input bit m, input logic w, input logic [31:0] a, input logic [31:0] d,
                        output int lat, output logic err, output logic [31:0] rd,
                        output logic [3:0] lm, output logic [3:0] pm,
                        output logic [3:0] hm, output logic [3:0] wm);
        lat = 0; err = 1'bx; rd = 'x; lm = '0; pm = '0; hm = '0; wm = '0;
        @(negedge clk);
        set_req(m, 1'b1, w, a, d);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            lat++;
            if (i < 4) begin
                lm[i] = cs_lomem; pm[i] = cs_pmon; hm[i] = cs_himem; wm[i] = mem_wen;
            end
            if (m ? m1_ack : m0_ack) begin
                err = m ? m1_err : m0_err;
                rd  = m ? m1_rdata : m0_rdata;
                set_req(m, 1'b0, 1'b0, 32'h0, 32'h0);
                return;
            end
        end
        set_req(m, 1'b0, 1'b0, 32'h0, 32'h0);
        fail_now("xfer");
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_cs"}, {cs_himem, cs_pmon, cs_lomem, mem_wen}, 4'b0000);
        chk({tag, "_ack_err"}, {m0_ack, m1_ack, m0_err, m1_err}, 4'b0000);
        chk({tag, "_m0_rdata"}, m0_rdata, 32'h0);
        chk({tag, "_m1_rdata"}, m1_rdata, 32'h0);
        chk({tag, "_mem_addr"}, mem_addr, 32'h0);
        chk({tag, "_mem_din"}, mem_din, 32'h0);
    endtask

    function automatic logic [31:0] pick_addr();
        case ($urandom_range(0, 7))
            0: return 32'($urandom_range(0, 7));
            1: return 32'h0000_F000 + 32'($urandom_range(0, 7));
            2: return 32'h0001_0000 + 32'($urandom_range(0, 7));
            3: return 32'h0001_FFF8 + 32'($urandom_range(0, 7));
            4: return 32'h0000_EFFC + 32'($urandom_range(0, 3));
            5: return 32'h0002_0000;
            6: return 32'h0100_0000;
            default: return 32'hFFFF_FFFF;
        endcase
    endfunction

    task automatic rnd_master(input bit m, input int n);
        bit done;
        int gap;
        for (int t = 0; t < n; t++) begin
            gap = $urandom_range(0, 3);
            if (gap > 0) begin
                set_req(m, 1'b0, 1'b0, 32'h0, 32'h0);
                repeat (gap) @(negedge clk);
            end
            set_req(m, 1'b1, 1'($urandom_range(0, 1)), pick_addr(), $urandom);
            done = 1'b0;
            for (int i = 0; i < 40 && !done; i++) begin
                @(negedge clk);
                if (m ? m1_ack : m0_ack) done = 1'b1;
                else if ($urandom_range(0, 3) == 0)
                    set_req(m, 1'b1, 1'($urandom_range(0, 1)), pick_addr(), $urandom);
            end
            if (!done) fail_now(m ? "rnd_m1" : "rnd_m0");
        end
        set_req(m, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin : main
        int          lat, n;
        logic        err, anyc, anyw, got;
        logic [31:0] rd;
        logic [3:0]  lm, pm, hm, wm;
        int          order [4];
        int          when  [4];

        reset = 1'b1;
        set_req(0, 1'b0, 1'b0, 32'h0, 32'h0);
        set_req(1, 1'b0, 1'b0, 32'h0, 32'h0);
        n_req = 1'b0; n_wen = 1'b0; n_addr = '0; n_wdata = '0;
        @(posedge clk); #1;
        chk_on = 1'b1;
        @(negedge clk);
        chk_reset_vals("rst");
        @(negedge clk);
        reset = 1'b0;

        // m0 write then read of lomem word 5
        xfer(0, 1'b1, 32'd5, 32'hDEAD_BEEF, lat, err, rd, lm, pm, hm, wm);
        chk("t1_wr_lat", lat, 3);
        chk("t1_wr_cs_lomem", lm, 4'b0001);
        chk("t1_wr_wen", wm, 4'b0001);
        chk("t1_wr_err", err, 1'b0);
        xfer(0, 1'b0, 32'd5, 32'h0, lat, err, rd, lm, pm, hm, wm);
        chk("t1_rd_lat", lat, 3);
        chk("t1_rd_data", rd, 32'hDEAD_BEEF);
        chk("t1_rd_err", err, 1'b0);
        chk("t1_rd_wen", wm, 4'b0000);

        // pmon overrides lomem
        emu[{2'd2, 32'h0000_F010}] = 32'h0B0B_0010;
        mmem[32'h0000_F010]       = 32'h0B0B_0010;
        xfer(0, 1'b0, 32'h0000_F010, 32'h0, lat, err, rd, lm, pm, hm, wm);
        chk("t2_cs_pmon", pm, 4'b0001);
        chk("t2_cs_lomem", lm, 4'b0000);
        chk("t2_data", rd, 32'h0B0B_0010);

        // unmapped write and read by m1
        xfer(1, 1'b1, 32'h0100_0000, 32'h5555_AAAA, lat, err, rd, lm, pm, hm, wm);
        chk("t5_wr_cs", {lm, pm, hm}, 12'h000);
        chk("t5_wr_wen", wm, 4'b0000);
        chk("t5_wr_err", err, 1'b1);
        xfer(1, 1'b0, 32'h0100_0000, 32'h0, lat, err, rd, lm, pm, hm, wm);
        chk("t5_rd_data", rd, 32'h0);
        chk("t5_rd_err", err, 1'b1);

        // himem present: top word works, one past the end is unmapped
        xfer(0, 1'b1, 32'h0001_FFFF, 32'h1234_5678, lat, err, rd, lm, pm, hm, wm);
        chk("t6_wr_cs_himem", hm, 4'b0001);
        chk("t6_wr_err", err, 1'b0);
        xfer(0, 1'b0, 32'h0001_FFFF, 32'h0, lat, err, rd, lm, pm, hm, wm);
        chk("t6_rd_data", rd, 32'h1234_5678);
        chk("t6_rd_err", err, 1'b0);
        xfer(0, 1'b1, 32'h0002_0000, 32'h0, lat, err, rd, lm, pm, hm, wm);
        chk("t6_end_err", err, 1'b1);
        chk("t6_end_cs", {lm, pm, hm, wm}, 16'h0000);

        // himem absent
        @(negedge clk);
        n_req = 1'b1; n_wen = 1'b1; n_addr = 32'h0001_0000; n_wdata = 32'hCAFE_0001;
        anyc = 1'b0; anyw = 1'b0; got = 1'b0; err = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            anyc |= n_cs_lo | n_cs_pm | n_cs_hi;
            anyw |= n_mem_wen;
            if (n_ack) begin got = 1'b1; err = n_err; end
        end
        n_req = 1'b0;
        chk("t6_nh_ack", got, 1'b1);
        chk("t6_nh_err", err, 1'b1);
        chk("t6_nh_cs_wen", {anyc, anyw}, 2'b00);

        // reset in RESP of an m0 read
        @(negedge clk);
        set_req(0, 1'b1, 1'b0, 32'd5, 32'h0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        set_req(0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        chk_reset_vals("t7");
        reset = 1'b0;
        got = 1'b0;
        repeat (4) begin
            @(negedge clk);
            got |= m0_ack | m1_ack;
        end
        chk("t7_no_ack", got, 1'b0);
        xfer(1, 1'b0, 32'd5, 32'h0, lat, err, rd, lm, pm, hm, wm);
        chk("t7_m1_lat", lat, 3);
        chk("t7_m1_data", rd, 32'hDEAD_BEEF);
        chk("t7_m1_err", err, 1'b0);

        // both requests held from reset
        @(negedge clk);
        reset = 1'b1;
        set_req(0, 1'b1, 1'b0, 32'd5, 32'h0);
        set_req(1, 1'b1, 1'b0, 32'h0000_0010, 32'h0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        n = 0;
        for (int i = 0; i < 40 && n < 4; i++) begin
            @(negedge clk);
            if (m0_ack || m1_ack) begin
                order[n] = m1_ack ? 1 : 0;
                when[n]  = i;
                n++;
            end
        end
        set_req(0, 1'b0, 1'b0, 32'h0, 32'h0);
        set_req(1, 1'b0, 1'b0, 32'h0, 32'h0);
        chk("t4_count", n, 4);
        for (int k = 0; k < n; k++) begin
            chk($sformatf("t4_order%0d", k), order[k], k % 2);
            if (k > 0) chk($sformatf("t4_gap%0d", k), when[k] - when[k-1], 4);
        end

        // random two-master traffic
        @(negedge clk);
        fork
            rnd_master(0, 60);
            rnd_master(1, 60);
        join
        repeat (6) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
